mux_sel_rr_arbiter: RTL

Round-robin arbiter that owns the select pins of the 4:1 data mux. It takes four per-channel request lines and produces the registered two-bit select (s1, s0) that steers the mux, plus a one-hot grant back to the requesters. A channel may hold the mux for at most MAX_HOLD consecutive cycles while others are waiting.

---
 rtl/mux_sel_pkg.sv | 8 +
 rtl/mux_sel_rr_pick.sv | 26 ++
 rtl/mux_sel_rr_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/mux_sel_pkg.sv
// Shared constants and state type for the 4:1 mux select round-robin arbiter.
package mux_sel_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int HOLD_W = 8;

  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/mux_sel_rr_pick.sv
// Rotating priority encoder: first requester after `last`, with `last` itself scanned at the end.
module mux_sel_rr_pick
  import mux_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic              any,
  output logic [SEL_W-1:0]  idx
);

  always_comb begin
    logic [SEL_W-1:0] cand;
    any  = 1'b0;
    idx  = last;
    cand = '0;
    // Walk from the farthest offset to the nearest so the nearest requester wins.
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_sel_rr_arbiter.sv
// Round-robin owner of the 4:1 mux select pins with a bounded hold time per owner.
module mux_sel_rr_arbiter
  import mux_sel_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] req,
  output logic              s1,
  output logic              s0,
  output logic [NUM_CH-1:0] gnt,
  output logic              busy,
  output logic [HOLD_W-1:0] hold_cnt
);

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    own_q, own_d;
  logic [SEL_W-1:0]    last_q, last_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [SEL_W-1:0]    pick_last;
  logic                pick_any;
  logic [SEL_W-1:0]    pick_idx;
  logic [NUM_CH-1:0]   own_mask;
  logic                others;
  logic                at_max;

  // While granted the search starts after the owner, which is the new `last` on any handover.
  assign pick_last = (state_q == GRANT) ? own_q : last_q;
  assign own_mask  = NUM_CH'(1) << own_q;
  assign others    = |(req & ~own_mask);
  assign at_max    = (hold_q == HOLD_W'(MAX_HOLD));

  mux_sel_rr_pick u_pick (
    .req  (req),
    .last (pick_last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    logic take;
    logic drop;
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    take    = 1'b0;
    drop    = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && pick_any) take = 1'b1;
        else                drop = 1'b1;
      end
      GRANT: begin
        if (!en) begin
          last_d = own_q;
          drop   = 1'b1;
        end else if (!req[own_q] || (at_max && others)) begin
          last_d = own_q;
          if (others) take = 1'b1;
          else        drop = 1'b1;
        end else if (at_max) begin
          hold_d = HOLD_W'(1);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: drop = 1'b1;
    endcase

    // Select only moves together with a new grant; on release it stays put.
    if (take) begin
      state_d = GRANT;
      own_d   = pick_idx;
      sel_d   = pick_idx;
      gnt_d   = NUM_CH'(1) << pick_idx;
      hold_d  = HOLD_W'(1);
    end else if (drop) begin
      state_d = IDLE;
      gnt_d   = '0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      own_q   <= '0;
      last_q  <= SEL_W'(NUM_CH - 1);
      sel_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
    end
  end

  assign s1       = sel_q[1];
  assign s0       = sel_q[0];
  assign gnt      = gnt_q;
  assign busy     = |gnt_q;
  assign hold_cnt = hold_q;

endmodule
